// File: rtl/spi_fetch_ctrl.sv
// spi_fetch_ctrl: turns CPU instruction-fetch / data requests into SPI master commands,
//   keeping an instruction stream open across sequential fetches with a one-entry prefetch buffer.
// Latency: request accept -> spi_start 1 cycle; spi_done -> resp_valid 1 cycle (buffer hit: accept -> resp 1 cycle).
// Backpressure: req_ready low while a transaction is in flight (WAIT/STOP) or a streamed fetch is pending.
// Ports: clk/rst_n (sync active-low); req_* CPU request (valid/ready); resp_* one-cycle response pulse;
//   spi_start/stop/cont command pulses and spi_* transaction parameters to the master; spi_data_out/spi_done from it.
module spi_fetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic        req_is_instr,
    input  logic        req_write,
    input  logic [5:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_compressed,
    output logic        spi_start,
    output logic        spi_stop,
    output logic        spi_cont,
    output logic        spi_write_enable,
    output logic        spi_is_instr,
    output logic [23:0] spi_addr,
    output logic [5:0]  spi_data_len,
    output logic [31:0] spi_data_in,
    input  logic [31:0] spi_data_out,
    input  logic        spi_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM,
        ST_STOP
    } state_t;

    state_t      state_q;

    // Registered outputs
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_cmp_q;
    logic        spi_start_q;
    logic        spi_stop_q;
    logic        spi_cont_q;
    logic        spi_we_q;
    logic        spi_is_instr_q;
    logic [23:0] spi_addr_q;
    logic [5:0]  spi_len_q;
    logic [31:0] spi_wdata_q;

    // Stream tracking: address of the next sequential instruction, prefetch buffer, pending fetch
    logic [23:0] next_addr_q;
    logic        buf_vld_q;
    logic [31:0] buf_data_q;
    logic        buf_cmp_q;
    logic        pend_q;

    // Request captured on a stream miss, replayed after the STOP cycle
    logic [23:0] lat_addr_q;
    logic        lat_is_instr_q;
    logic        lat_we_q;
    logic [5:0]  lat_len_q;
    logic [31:0] lat_wdata_q;

    // Combinational helpers
    logic        accept_d;
    logic        hit_d;
    logic        req_we_d;
    logic [5:0]  req_len_d;
    logic        done_cmp_d;
    logic [31:0] done_word_d;
    logic [23:0] done_step_d;
    logic [23:0] buf_step_d;

    always_comb begin
        accept_d  = req_valid && req_ready_q;
        hit_d     = accept_d && req_is_instr && (req_addr == next_addr_q);
        // Writes only exist for data accesses; instruction fetches always move one 32-bit word
        req_we_d  = req_write && !req_is_instr;
        req_len_d = req_is_instr ? 6'd32 : req_len;
        // The master returns bytes in flash order {b0,b1,b2,b3}; b0 carries the RISC-V length bits
        done_cmp_d  = (spi_data_out[25:24] != 2'b11);
        done_word_d = done_cmp_d
                    ? {16'h0000, spi_data_out[23:16], spi_data_out[31:24]}
                    : {spi_data_out[7:0], spi_data_out[15:8], spi_data_out[23:16], spi_data_out[31:24]};
        done_step_d = done_cmp_d ? 24'd2 : 24'd4;
        buf_step_d  = buf_cmp_q ? 24'd2 : 24'd4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_cmp_q     <= 1'b0;
            spi_start_q    <= 1'b0;
            spi_stop_q     <= 1'b0;
            spi_cont_q     <= 1'b0;
            spi_we_q       <= 1'b0;
            spi_is_instr_q <= 1'b0;
            spi_addr_q     <= '0;
            spi_len_q      <= '0;
            spi_wdata_q    <= '0;
            next_addr_q    <= '0;
            buf_vld_q      <= 1'b0;
            buf_data_q     <= '0;
            buf_cmp_q      <= 1'b0;
            pend_q         <= 1'b0;
            lat_addr_q     <= '0;
            lat_is_instr_q <= 1'b0;
            lat_we_q       <= 1'b0;
            lat_len_q      <= '0;
            lat_wdata_q    <= '0;
        end else begin
            // Command and response strobes are single-cycle pulses
            spi_start_q  <= 1'b0;
            spi_stop_q   <= 1'b0;
            spi_cont_q   <= 1'b0;
            resp_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        spi_addr_q     <= req_addr;
                        spi_is_instr_q <= req_is_instr;
                        spi_we_q       <= req_we_d;
                        spi_len_q      <= req_len_d;
                        spi_wdata_q    <= req_wdata;
                        spi_start_q    <= 1'b1;
                        req_ready_q    <= 1'b0;
                        state_q        <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (spi_done) begin
                        resp_valid_q <= 1'b1;
                        req_ready_q  <= 1'b1;
                        if (spi_is_instr_q) begin
                            resp_data_q <= done_word_d;
                            resp_cmp_q  <= done_cmp_d;
                            next_addr_q <= spi_addr_q + done_step_d;
                            buf_vld_q   <= 1'b0;
                            pend_q      <= 1'b0;
                            state_q     <= ST_STREAM;
                        end else begin
                            resp_data_q <= spi_we_q ? 32'h0 : spi_data_out;
                            resp_cmp_q  <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end

                ST_STREAM: begin
                    if (accept_d && !hit_d) begin
                        // Miss: close the stream; any word arriving now is dropped with it
                        lat_addr_q     <= req_addr;
                        lat_is_instr_q <= req_is_instr;
                        lat_we_q       <= req_we_d;
                        lat_len_q      <= req_len_d;
                        lat_wdata_q    <= req_wdata;
                        buf_vld_q      <= 1'b0;
                        spi_stop_q     <= 1'b1;
                        req_ready_q    <= 1'b0;
                        state_q        <= ST_STOP;
                    end else if (hit_d) begin
                        spi_cont_q <= 1'b1;
                        if (buf_vld_q) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= buf_data_q;
                            resp_cmp_q   <= buf_cmp_q;
                            next_addr_q  <= next_addr_q + buf_step_d;
                            // A word landing in the same cycle refills the slot just freed
                            buf_vld_q    <= spi_done;
                            if (spi_done) begin
                                buf_data_q <= done_word_d;
                                buf_cmp_q  <= done_cmp_d;
                            end
                        end else if (spi_done) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= done_word_d;
                            resp_cmp_q   <= done_cmp_d;
                            next_addr_q  <= next_addr_q + done_step_d;
                        end else begin
                            pend_q      <= 1'b1;
                            req_ready_q <= 1'b0;
                        end
                    end else if (spi_done) begin
                        if (pend_q) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= done_word_d;
                            resp_cmp_q   <= done_cmp_d;
                            next_addr_q  <= next_addr_q + done_step_d;
                            pend_q       <= 1'b0;
                            req_ready_q  <= 1'b1;
                        end else if (!buf_vld_q) begin
                            buf_vld_q  <= 1'b1;
                            buf_data_q <= done_word_d;
                            buf_cmp_q  <= done_cmp_d;
                        end else begin
                            // Overflow: nobody consumed the buffered word, give up on the stream
                            buf_vld_q  <= 1'b0;
                            spi_stop_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end
                end

                ST_STOP: begin
                    spi_addr_q     <= lat_addr_q;
                    spi_is_instr_q <= lat_is_instr_q;
                    spi_we_q       <= lat_we_q;
                    spi_len_q      <= lat_len_q;
                    spi_wdata_q    <= lat_wdata_q;
                    spi_start_q    <= 1'b1;
                    state_q        <= ST_WAIT;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_data        = resp_data_q;
    assign resp_compressed  = resp_cmp_q;
    assign spi_start        = spi_start_q;
    assign spi_stop         = spi_stop_q;
    assign spi_cont         = spi_cont_q;
    assign spi_write_enable = spi_we_q;
    assign spi_is_instr     = spi_is_instr_q;
    assign spi_addr         = spi_addr_q;
    assign spi_data_len     = spi_len_q;
    assign spi_data_in      = spi_wdata_q;

endmodule
